// File: rtl/waveform_loader.sv
// Loads or verifies the 16384 x 2-bit waveform LUT through one RAM port.
// Input bytes are unpacked LSB pair first and issued one entry per clock.
module waveform_loader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_din,
  input  logic [1:0]        ram_dout,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mismatch_addr,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t            state;
  logic              mode_r;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [7:0]        hold;
  logic [1:0]        slot;
  logic              full;
  logic              exp_valid;
  logic [1:0]        exp_pair;
  logic [ADDR_W-1:0] exp_addr;
  logic              mismatch_r;
  logic [ADDR_W-1:0] mismatch_addr_r;

  logic              issue;
  logic              last;
  logic              accept;
  logic [1:0]        pair;
  logic [LEN_W-1:0]  len_clamped;

  // Stream handshake: a byte transfers on every rising edge where
  // in_valid && in_ready; in_ready depends only on internal registers.
  always_comb begin
    issue       = (state == S_RUN) && full;
    last        = issue && (rem == LEN_W'(1));
    pair        = hold[{slot, 1'b0} +: 2];
    in_ready    = (state == S_RUN) && (!full || ((slot == 2'd3) && !last));
    accept      = in_ready && in_valid;
    len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  end

  assign ram_we        = issue && !mode_r;
  assign ram_addr      = addr;
  assign ram_din       = pair;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign mismatch      = mismatch_r;
  assign mismatch_addr = mismatch_addr_r;
  assign fsm_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      mode_r          <= 1'b0;
      addr            <= '0;
      rem             <= '0;
      hold            <= '0;
      slot            <= '0;
      full            <= 1'b0;
      exp_valid       <= 1'b0;
      exp_pair        <= '0;
      exp_addr        <= '0;
      mismatch_r      <= 1'b0;
      mismatch_addr_r <= '0;
    end else begin
      // Read data returns one cycle after the address, so the compare
      // runs on the delayed copy; this also lets an aborted issue finish.
      exp_valid <= issue && mode_r;
      exp_pair  <= pair;
      exp_addr  <= addr;
      if (exp_valid && (ram_dout != exp_pair) && !mismatch_r) begin
        mismatch_r      <= 1'b1;
        mismatch_addr_r <= exp_addr;
      end

      if (abort) begin
        state <= S_IDLE;
        full  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              mode_r          <= mode;
              addr            <= start_addr;
              rem             <= len_clamped;
              mismatch_r      <= 1'b0;
              mismatch_addr_r <= '0;
              full            <= 1'b0;
              state           <= (length == '0) ? S_FLUSH : S_RUN;
            end
          end
          S_RUN: begin
            if (issue) begin
              addr <= addr + ADDR_W'(1);
              rem  <= rem - LEN_W'(1);
              if (last) begin
                state <= S_FLUSH;
                full  <= 1'b0;
              end else if (slot == 2'd3) begin
                // Refill on the same edge to keep one entry per clock.
                if (accept) begin
                  hold <= in_data;
                  slot <= 2'd0;
                end else begin
                  full <= 1'b0;
                end
              end else begin
                slot <= slot + 2'd1;
              end
            end else if (accept) begin
              hold <= in_data;
              slot <= 2'd0;
              full <= 1'b1;
            end
          end
          S_FLUSH: state <= S_DONE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_waveform_loader.sv
// Directed bench for waveform_loader: expected RAM writes and done pulses
// are queued with their cycle numbers and checked by a negedge monitor.
module tb_waveform_loader;

  localparam int ADDR_W = 14;
  localparam int LEN_W  = 15;
  localparam int W      = 48;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_din;
  logic [1:0]        ram_dout;
  logic              busy;
  logic              done;
  logic              mismatch;
  logic [ADDR_W-1:0] mismatch_addr;
  logic [1:0]        fsm_state;

  waveform_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .start_addr(start_addr), .length(length), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .mismatch(mismatch),
    .mismatch_addr(mismatch_addr), .fsm_state(fsm_state)
  );

  // synchronous-read RAM model
  logic [1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [31:0]  done_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int c, input logic [ADDR_W-1:0] a, input logic [1:0] d);
    exp_q.push_back({c[31:0], a, d});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got cycle %0d addr %0h data %0d expected no write",
                   cyc, ram_addr, ram_din);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("write", 64'({cyc[31:0], ram_addr, ram_din}), 64'(e));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          logic [31:0] dc;
          dc = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(dc));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [ADDR_W-1:0] a,
                          input logic [LEN_W-1:0] len, output int s);
    start = 1'b1;
    mode = m;
    start_addr = a;
    length = len;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic stream_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 64 && !in_ready; i++) tick();
    check("stream_accept", 64'(in_ready), 64'(1));
    tick();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_reached", 64'(busy), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s2;
    logic [1:0] d1 [8];
    logic [7:0] b;
    logic [ADDR_W-1:0] a;
    d1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

    repeat (3) tick();
    check("reset_outputs", 64'({in_ready, ram_we, ram_addr, ram_din, busy, done,
                                mismatch, mismatch_addr, fsm_state}), 64'(0));
    rst_n = 1'b1;
    tick();

    // LOAD 8 entries at 0x0010
    do_start(1'b0, 14'h0010, 15'd8, s);
    for (int i = 0; i < 8; i++) push_wr(s + 2 + i, 14'h0010 + 14'(i), d1[i]);
    done_q.push_back(32'(s + 11));
    stream_byte(8'hE4);
    stream_byte(8'h1B);
    in_valid = 1'b0;
    wait_idle(50);
    for (int i = 0; i < 8; i++) check("t1_ram", 64'(mem[16 + i]), 64'(d1[i]));

    // LOAD across the address wrap
    do_start(1'b0, 14'h3FFE, 15'd4, s);
    push_wr(s + 2, 14'h3FFE, 2'd0);
    push_wr(s + 3, 14'h3FFF, 2'd3);
    push_wr(s + 4, 14'h0000, 2'd1);
    push_wr(s + 5, 14'h0001, 2'd2);
    done_q.push_back(32'(s + 7));
    stream_byte(8'h9C);
    in_valid = 1'b0;
    wait_idle(50);

    // LOAD 5 entries with a stalled stream
    do_start(1'b0, 14'h0100, 15'd5, s);
    for (int i = 0; i < 4; i++) push_wr(s + 2 + i, 14'h0100 + 14'(i), 2'd3);
    push_wr(s + 9, 14'h0104, 2'd1);
    done_q.push_back(32'(s + 11));
    stream_byte(8'hFF);
    in_valid = 1'b0;
    while (cyc < s + 8) tick();
    stream_byte(8'h55);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_in_ready_low", 64'(in_ready), 64'(0));
      tick();
    end
    wait_idle(50);

    // VERIFY with one bad entry, then a clean rerun
    do_start(1'b1, 14'h0010, 15'd8, s);
    done_q.push_back(32'(s + 11));
    stream_byte(8'hE4);
    stream_byte(8'h1F);
    in_valid = 1'b0;
    wait_idle(50);
    check("t4_mismatch", 64'(mismatch), 64'(1));
    check("t4_mismatch_addr", 64'(mismatch_addr), 64'(14'h0015));
    do_start(1'b1, 14'h0010, 15'd8, s);
    check("t4_mismatch_cleared", 64'(mismatch), 64'(0));
    done_q.push_back(32'(s + 11));
    stream_byte(8'hE4);
    stream_byte(8'h1B);
    in_valid = 1'b0;
    wait_idle(50);
    check("t4_rerun_mismatch", 64'(mismatch), 64'(0));

    // abort after the second write
    do_start(1'b0, 14'h0200, 15'd16, s);
    push_wr(s + 2, 14'h0200, 2'd0);
    push_wr(s + 3, 14'h0201, 2'd1);
    push_wr(s + 4, 14'h0202, 2'd2);
    stream_byte(8'hE4);
    in_data = 8'h1B;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("t5_busy_after_abort", 64'(busy), 64'(0));
    check("t5_we_after_abort", 64'(ram_we), 64'(0));
    tick();

    // new start right after, with length 0
    do_start(1'b0, 14'h0300, 15'd0, s2);
    done_q.push_back(32'(s2 + 2));
    check("t6_busy_after_start", 64'(busy), 64'(1));
    check("t6_in_ready_flush", 64'(in_ready), 64'(0));
    tick();
    check("t6_in_ready_done", 64'(in_ready), 64'(0));
    wait_idle(10);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    length = 15'd4;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t7_start_ignored", 64'(busy), 64'(0));
    tick();

    // asynchronous reset mid-load
    do_start(1'b0, 14'h0300, 15'd8, s);
    push_wr(s + 2, 14'h0300, 2'd0);
    stream_byte(8'hE4);
    in_valid = 1'b0;
    tick();
    check("t8_we_before_reset", 64'(ram_we), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_async_reset_outputs", 64'({in_ready, ram_we, ram_addr, ram_din, busy, done,
                                         mismatch, mismatch_addr, fsm_state}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // oversized length clamps to the full LUT, wrapping from 0x3000
    do_start(1'b0, 14'h3000, 15'h7FFF, s);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      b = 8'(i / 4) ^ 8'hA5;
      a = 14'h3000 + 14'(i);
      push_wr(s + 2 + i, a, 2'((b >> (2 * (i % 4))) & 8'h03));
    end
    done_q.push_back(32'(s + 2 + (1 << ADDR_W) - 1 + 2));
    for (int i = 0; i < (1 << ADDR_W) / 4; i++) stream_byte(8'(i) ^ 8'hA5);
    in_valid = 1'b0;
    wait_idle(100);
    tick();

    check("write_queue_drained", 64'(exp_q.size()), 64'(0));
    check("done_queue_drained", 64'(done_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/waveform_loader.md
Name: waveform_loader

Overview:
- Sequences host loading and verification of the 16384 x 2-bit waveform lookup dual-port RAM through one RAM port.
- Accepts a byte stream on a valid/ready interface and unpacks each byte into four 2-bit LUT entries.
- Writes the entries to consecutive RAM addresses (LOAD), or reads them back and compares them with the stream (VERIFY).
- The other RAM port stays with the pixel pipeline; this block only ever drives its own port.

Parameters:
- ADDR_W, 14, RAM address width; the address counter wraps modulo 2^ADDR_W.
- LEN_W, 15, width of the entry-count input; must hold 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe, sampled only in IDLE
- mode  in  1  0 = LOAD, 1 = VERIFY; sampled with start
- start_addr  in  ADDR_W  first LUT address; sampled with start
- length  in  LEN_W  number of 2-bit entries to process; sampled with start
- abort  in  1  cancels the current operation
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte; entries are taken LSB pair first ([1:0], [3:2], [5:4], [7:6])
- in_ready  out  1  block accepts in_data this cycle
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  2  RAM write data
- ram_dout  in  2  RAM read data, valid one cycle after the address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an operation completes
- mismatch  out  1  sticky VERIFY failure flag; cleared by the next start
- mismatch_addr  out  ADDR_W  address of the first mismatch

Behaviour:
- Reset values (asserted asynchronously): all outputs 0, state IDLE, holding register empty.
- States:
  - IDLE: start=1 latches mode, start_addr and length, clears mismatch and mismatch_addr, then goes to RUN. If length == 0, it goes to FLUSH instead.
  - RUN: unpacks and issues entries (rules below).
  - FLUSH: waits one cycle for the final read data, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Holding register: 8-bit byte plus a 2-bit slot index.
  - in_ready=1 in RUN when the register is empty, or when slot 3 is being issued this cycle and more entries remain after it.
  - A byte is therefore consumed on the same cycle that slot 3 of the previous byte issues, giving a sustained 1 entry per clock.
  - in_ready=0 in IDLE, FLUSH and DONE.
- Entry issue (RUN, register full):
  - One entry per cycle, in the order slot 0..3.
  - ram_addr = current address; the address then increments with wrap (0x3FFF -> 0x0000).
  - The remaining-entry count decrements by 1 per issued entry.
  - LOAD: ram_we=1 and ram_din = the selected pair.
  - VERIFY: ram_we=0; the expected pair and its address are pipelined one cycle.
- VERIFY compare: on the cycle after each issue, ram_dout is compared with the expected pair.
  - On the first inequality, set mismatch=1 and capture mismatch_addr.
  - Later mismatches do not overwrite mismatch_addr.
- Completion: when the entry with remaining count 1 issues, the next state is FLUSH. This applies in both modes, so done always comes 2 cycles after the last issue.
  - If length is not a multiple of 4, the unused upper pairs of the last byte are discarded and no further byte is requested.
- length is clamped to 2^ADDR_W; a larger value processes 16384 entries.
- Stall: if in_valid=0 while the register is empty, nothing is issued, ram_we=0 and the address holds.
- Outputs between issues: ram_we=0 whenever no entry issues; ram_addr holds its last value.
- abort, any non-IDLE state:
  - Next state is IDLE and the holding register is cleared.
  - No done pulse.
  - ram_we is 0 from the next cycle; an entry issued on the abort cycle itself still completes.
  - mismatch keeps its value.
- abort and start in the same IDLE cycle: abort wins and start is ignored.
- start while busy: ignored.
- rst_n low mid-operation: everything returns to reset values at once, and ram_we drops without waiting for a clock edge.

Test Plan:
- LOAD, start_addr=0x0010, length=8, bytes 0xE4 then 0x1B streamed with in_valid always high -> writes at 0x10..0x17 with data 0,1,2,3,3,2,1,0 on consecutive cycles; done 2 cycles after the 0x17 write; the RAM model matches.
- LOAD, start_addr=0x3FFE, length=4, byte 0x9C -> writes 0,3,1,2 to 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- LOAD, length=5, bytes 0xFF, 0x55, in_valid deasserted for 3 cycles between the bytes -> exactly 5 writes with a 3-cycle ram_we gap; in_ready never rises after the second byte.
- VERIFY after the first test's load, stream 0xE4, 0x1F -> mismatch=1, mismatch_addr=0x15, done pulses; a rerun with 0x1B clears mismatch.
- abort asserted after the 2nd write of a length=16 load -> at most 3 writes total, no done, busy=0 on the next cycle; a new start is accepted the cycle after that.
- length=0 -> no writes, in_ready stays 0, done 2 cycles after start; rst_n pulsed low mid-load -> ram_we drops asynchronously and all outputs return to 0.
